// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: op codes, ctrl field positions and multiplier sizing.
package ex_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int unsigned CTRL_OP_LSB  = 0;
    localparam int unsigned CTRL_OP_MSB  = 3;
    localparam int unsigned CTRL_IMM_SEL = 4;
    localparam int unsigned CTRL_VALID   = 15;

    localparam int unsigned MUL_ITERS = 64;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_ITERS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    function automatic logic [63:0] sext_imm(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low 64 bits of A*B.
module ex_mul_seq
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        done_o,
    output logic [63:0] product_o
);

    logic                 busy_q, busy_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]          mcand_q, mcand_d;
    logic [63:0]          mplier_q, mplier_d;
    logic [63:0]          acc_q, acc_d;
    logic [63:0]          step_acc;

    // The final iteration is folded into product_o so the result is ready on the completion edge.
    assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == MUL_CNT_W'(MUL_ITERS - 1));
    assign product_o = step_acc;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[63:1]};
            cnt_d    = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU into the EX/MEM register, plus an optional
// 65-cycle iterative multiplier enabled by defining EX_MUL_EN.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] EX_dA,
    input  logic [63:0] EX_dB,
    input  logic [15:0] EX_IMM,
    input  logic [4:0]  EX_rD,
    input  logic [15:0] EX_EX_ctrl,
    input  logic [4:0]  EX_WB_ctrl,
    output logic [63:0] MEM_result,
    output logic [63:0] MEM_dB,
    output logic [4:0]  MEM_rD,
    output logic [4:0]  MEM_WB_ctrl,
    output logic        ex_busy
);

    logic [3:0]  op;
    logic        imm_sel;
    logic        valid;
    logic        ctrl_unused;
    logic [63:0] operand_b;
    logic [5:0]  shamt;
    logic [63:0] alu_result;

    logic [63:0] result_q, result_d;
    logic [63:0] db_q, db_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  wb_q, wb_d;

    assign op          = EX_EX_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
    assign imm_sel     = EX_EX_ctrl[CTRL_IMM_SEL];
    assign valid       = EX_EX_ctrl[CTRL_VALID];
    assign ctrl_unused = ^EX_EX_ctrl[CTRL_VALID-1:CTRL_IMM_SEL+1];

    assign operand_b = imm_sel ? sext_imm(EX_IMM) : EX_dB;
    assign shamt     = operand_b[5:0];

    // MUL and codes 10-15 fall through to zero; MUL is produced by ex_mul_seq when enabled.
    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = EX_dA + operand_b;
            OP_SUB:  alu_result = EX_dA - operand_b;
            OP_AND:  alu_result = EX_dA & operand_b;
            OP_OR:   alu_result = EX_dA | operand_b;
            OP_XOR:  alu_result = EX_dA ^ operand_b;
            OP_SLL:  alu_result = EX_dA << shamt;
            OP_SRL:  alu_result = EX_dA >> shamt;
            OP_SRA:  alu_result = $signed(EX_dA) >>> shamt;
            OP_SLT:  alu_result = {63'd0, $signed(EX_dA) < $signed(operand_b)};
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    ex_state_e   state_q, state_d;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_product;
    logic [63:0] lat_db_q, lat_db_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic [4:0]  lat_wb_q, lat_wb_d;

    assign mul_start = (state_q == ST_IDLE) && valid && (op == OP_MUL);

    ex_mul_seq u_mul (
        .clk       (clk),
        .rst_n     (rst),
        .start_i   (mul_start),
        .a_i       (EX_dA),
        .b_i       (operand_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            lat_db_q <= '0;
            lat_rd_q <= '0;
            lat_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_db_q <= lat_db_d;
            lat_rd_q <= lat_rd_d;
            lat_wb_q <= lat_wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Every non-completion edge while busy writes a bubble into EX/MEM.
    always_comb begin
        ex_busy  = rst && (mul_start || (state_q == ST_MUL));
        lat_db_d = mul_start ? EX_dB      : lat_db_q;
        lat_rd_d = mul_start ? EX_rD      : lat_rd_q;
        lat_wb_d = mul_start ? EX_WB_ctrl : lat_wb_q;
        result_d = '0;
        db_d     = '0;
        rd_d     = '0;
        wb_d     = '0;
        if (state_q == ST_IDLE && valid && !mul_start) begin
            result_d = alu_result;
            db_d     = EX_dB;
            rd_d     = EX_rD;
            wb_d     = EX_WB_ctrl;
        end else if (state_q == ST_MUL && mul_done) begin
            result_d = mul_product;
            db_d     = lat_db_q;
            rd_d     = lat_rd_q;
            wb_d     = lat_wb_q;
        end
    end
`else
    always_comb begin
        ex_busy  = 1'b0;
        result_d = '0;
        db_d     = '0;
        rd_d     = '0;
        wb_d     = '0;
        if (valid) begin
            result_d = alu_result;
            db_d     = EX_dB;
            rd_d     = EX_rD;
            wb_d     = EX_WB_ctrl;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            db_q     <= '0;
            rd_q     <= '0;
            wb_q     <= '0;
        end else begin
            result_q <= result_d;
            db_q     <= db_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
        end
    end

    assign MEM_result  = result_q;
    assign MEM_dB      = db_q;
    assign MEM_rD      = rd_q;
    assign MEM_WB_ctrl = wb_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; MUL sequences are exercised when EX_MUL_EN is defined.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [63:0] dA, dB;
    logic [15:0] imm;
    logic [4:0]  rD;
    logic [15:0] ex_ctrl;
    logic [4:0]  wb_ctrl;
    logic [63:0] mem_result, mem_db;
    logic [4:0]  mem_rd, mem_wb;
    logic        busy;

    int n_vec = 0;
    int n_mis = 0;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .EX_dA       (dA),
        .EX_dB       (dB),
        .EX_IMM      (imm),
        .EX_rD       (rD),
        .EX_EX_ctrl  (ex_ctrl),
        .EX_WB_ctrl  (wb_ctrl),
        .MEM_result  (mem_result),
        .MEM_dB      (mem_db),
        .MEM_rD      (mem_rd),
        .MEM_WB_ctrl (mem_wb),
        .ex_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        imm_sel;
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  wb;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Unused ctrl bits carry a fixed junk pattern to show they are ignored.
    task automatic drive(input logic [3:0] op, input logic isel, input logic v,
                         input logic [63:0] a, input logic [63:0] b, input logic [15:0] im,
                         input logic [4:0] rd, input logic [4:0] wb);
        dA      = a;
        dB      = b;
        imm     = im;
        rD      = rd;
        wb_ctrl = wb;
        ex_ctrl = {v, 10'h2A5, isel, op};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 1'b0, 1'b1, 64'd5, 64'd7, 16'h0000, 5'd3, 5'h11, 64'd12};
        vecs[1]  = '{4'd1, 1'b1, 1'b1, 64'd0, 64'h1234, 16'hFFFF, 5'd4, 5'h12, 64'd1};
        vecs[2]  = '{4'd7, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 16'h0, 5'd5, 5'h13, 64'hF800_0000_0000_0000};
        vecs[3]  = '{4'd2, 1'b0, 1'b1, 64'hF0F0, 64'hFF00, 16'h0, 5'd6, 5'h14, 64'hF000};
        vecs[4]  = '{4'd3, 1'b0, 1'b1, 64'hF0F0, 64'h0F0F, 16'h0, 5'd7, 5'h15, 64'hFFFF};
        vecs[5]  = '{4'd4, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_0000_0000, 16'h0, 5'd8, 5'h16, 64'h0000_FFFF_FFFF_0000};
        vecs[6]  = '{4'd5, 1'b0, 1'b1, 64'd1, 64'h43, 16'h0, 5'd9, 5'h17, 64'd8};
        vecs[7]  = '{4'd6, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h104, 16'h0, 5'd10, 5'h18, 64'h0800_0000_0000_0000};
        vecs[8]  = '{4'd8, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 16'h0, 5'd11, 5'h19, 64'd1};
        vecs[9]  = '{4'd8, 1'b0, 1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0, 5'd12, 5'h1A, 64'd0};
        vecs[10] = '{4'd8, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 16'hFFFE, 5'd13, 5'h1B, 64'd1};
        vecs[11] = '{4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 16'h0, 5'd14, 5'h1C, 64'd1};
        vecs[12] = '{4'd0, 1'b1, 1'b1, 64'd10, 64'd99, 16'h8000, 5'd15, 5'h1D, 64'hFFFF_FFFF_FFFF_800A};
        vecs[13] = '{4'd1, 1'b0, 1'b1, 64'd3, 64'd5, 16'h0, 5'd16, 5'h1E, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[14] = '{4'd15, 1'b0, 1'b1, 64'd5, 64'd7, 16'h0, 5'd17, 5'h01, 64'd0};
        vecs[15] = '{4'd0, 1'b0, 1'b0, 64'd5, 64'd7, 16'h0, 5'd18, 5'h02, 64'd0};

        rst = 1'b0;
        drive(4'd0, 1'b0, 1'b1, 64'd1, 64'd2, 16'h0, 5'd1, 5'h1F);
        #12;
        chk("reset_result", mem_result, 64'd0);
        chk("reset_dB", mem_db, 64'd0);
        chk("reset_rD", {59'd0, mem_rd}, 64'd0);
        chk("reset_wb", {59'd0, mem_wb}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].imm_sel, vecs[i].valid, vecs[i].a, vecs[i].b,
                  vecs[i].imm, vecs[i].rd, vecs[i].wb);
            #1;
            chk($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd0);
            step();
            chk($sformatf("vec%0d_result", i), mem_result, vecs[i].exp);
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_wb", i), {59'd0, mem_wb}, {59'd0, vecs[i].wb});
                chk($sformatf("vec%0d_rD", i), {59'd0, mem_rd}, {59'd0, vecs[i].rd});
                chk($sformatf("vec%0d_dB", i), mem_db, vecs[i].b);
            end else begin
                chk($sformatf("vec%0d_bubble_wb", i), {59'd0, mem_wb}, 64'd0);
            end
        end

`ifdef EX_MUL_EN
        // MUL 3 * -2 with an ADD held behind it during the busy window.
        drive(4'd9, 1'b0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 16'h0, 5'd7, 5'h1F);
        #1;
        chk("mul1_accept_busy", {63'd0, busy}, 64'd1);
        step();
        drive(4'd0, 1'b0, 1'b1, 64'd100, 64'd1, 16'h0, 5'd2, 5'h03);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mul1_busy_c%0d", i), {63'd0, busy}, 64'd1);
            chk($sformatf("mul1_bubble_c%0d", i), {59'd0, mem_wb}, 64'd0);
            step();
        end
        chk("mul1_result", mem_result, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul1_rD", {59'd0, mem_rd}, 64'd7);
        chk("mul1_wb", {59'd0, mem_wb}, 64'h1F);
        chk("mul1_dB", mem_db, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mul1_done_busy", {63'd0, busy}, 64'd0);
        step();
        chk("held_add_result", mem_result, 64'd101);
        chk("held_add_wb", {59'd0, mem_wb}, 64'h03);

        // Back-to-back MULs from the same held instruction.
        drive(4'd9, 1'b0, 1'b1, 64'h1_0000_0001, 64'hFFFF_FFFF, 16'h0, 5'd9, 5'h0C);
        step();
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mul2_busy_c%0d", i), {63'd0, busy}, 64'd1);
            chk($sformatf("mul2_bubble_c%0d", i), {59'd0, mem_wb}, 64'd0);
            step();
        end
        chk("mul2_result", mem_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul2_wb", {59'd0, mem_wb}, 64'h0C);
        chk("mul3_accept_busy", {63'd0, busy}, 64'd1);
        step();
        drive(4'd0, 1'b0, 1'b0, 64'd0, 64'd0, 16'h0, 5'd0, 5'h00);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mul3_busy_c%0d", i), {63'd0, busy}, 64'd1);
            chk($sformatf("mul3_bubble_c%0d", i), {59'd0, mem_wb}, 64'd0);
            step();
        end
        chk("mul3_result", mem_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul3_wb", {59'd0, mem_wb}, 64'h0C);
        chk("mul3_done_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a MUL abandons it.
        drive(4'd9, 1'b0, 1'b1, 64'd5, 64'd5, 16'h0, 5'd11, 5'h0B);
        step();
        for (int i = 0; i < 30; i++) step();
        #2;
        rst = 1'b0;
        #1;
        chk("rstmul_result", mem_result, 64'd0);
        chk("rstmul_dB", mem_db, 64'd0);
        chk("rstmul_rD", {59'd0, mem_rd}, 64'd0);
        chk("rstmul_wb", {59'd0, mem_wb}, 64'd0);
        chk("rstmul_busy", {63'd0, busy}, 64'd0);
        rst = 1'b1;
        drive(4'd0, 1'b0, 1'b1, 64'd20, 64'd22, 16'h0, 5'd4, 5'h09);
        #1;
        chk("post_rst_add_busy", {63'd0, busy}, 64'd0);
        step();
        chk("post_rst_add_result", mem_result, 64'd42);
        chk("post_rst_add_wb", {59'd0, mem_wb}, 64'h09);
`else
        drive(4'd9, 1'b0, 1'b1, 64'd3, 64'd4, 16'h0, 5'd6, 5'h15);
        #1;
        chk("nomul_accept_busy", {63'd0, busy}, 64'd0);
        step();
        chk("nomul_result", mem_result, 64'd0);
        chk("nomul_wb", {59'd0, mem_wb}, 64'h15);
        chk("nomul_busy", {63'd0, busy}, 64'd0);
        step();
        chk("nomul_busy2", {63'd0, busy}, 64'd0);
        chk("nomul_result2", mem_result, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Ports: clk  in  1  rising-edge clock for all state.
REQ-002 Ports: rst  in  1  asynchronous, active-low reset.
REQ-003 Ports: EX_dA  in  64  operand A, from ID/EX register.
REQ-004 Ports: EX_dB  in  64  operand B / store data.
REQ-005 Ports: EX_IMM  in  16  immediate, sign-extended to 64 when selected.
REQ-006 Ports: EX_rD  in  5  destination register.
REQ-007 Ports: EX_EX_ctrl  in  16  [3:0] op, [4] imm select, [15] valid, other bits ignored.
REQ-008 Ports: EX_WB_ctrl  in  5  write-back control, carried through unchanged.
REQ-009 Ports: MEM_result  out  64  registered ALU/MUL result.
REQ-010 Ports: MEM_dB  out  64  registered store data.
REQ-011 Ports: MEM_rD  out  5  registered destination register.
REQ-012 Ports: MEM_WB_ctrl  out  5  registered write-back control; 0 marks a bubble.
REQ-013 Ports: ex_busy  out  1  stall request to the hazard unit; freezes PC and IF/ID and bubbles ID/EX.

Function
REQ-014 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 MUL; codes 10-15 SHALL produce result 0.
REQ-015 Operand B SHALL be sign-extended EX_IMM when bit [4] is 1, otherwise EX_dB; shifts SHALL use B[5:0]; arithmetic SHALL wrap modulo 2^64.
REQ-016 FSM states SHALL be IDLE and MUL.
REQ-017 In IDLE, a valid non-MUL op SHALL load MEM_* on the next edge, giving 1-cycle latency with ex_busy low.
REQ-018 In IDLE, an invalid input (bit [15] = 0) SHALL load a bubble: MEM_WB_ctrl = 0, MEM_result = 0.
REQ-019 In IDLE, a valid MUL SHALL drive ex_busy high combinationally in that same cycle, latch A, B, dB, rD and WB_ctrl, and enter MUL with count 0 on the edge.
REQ-020 In MUL, the block SHALL perform one shift-add iteration per cycle for 64 cycles and produce the low 64 bits of the product (unsigned and signed agree).
REQ-021 On the 64th MUL edge, MEM_* SHALL load the product and the latched fields, and the state SHALL return to IDLE.
REQ-022 ex_busy SHALL stay high in every MUL cycle; total busy time SHALL be 65 cycles, including the accept cycle.
REQ-023 While busy, MEM_WB_ctrl SHALL be 0 on every edge except the completion edge, and EX_* inputs SHALL be ignored.
REQ-024 On the cycle after completion, ex_busy SHALL be low and a new instruction SHALL be accepted normally; back-to-back MULs SHALL each take 65 cycles.

Reset
REQ-025 rst low SHALL asynchronously clear the FSM to IDLE, the counter, the latched operands and all MEM_* outputs to 0, and force ex_busy to 0.
REQ-026 Reset during MUL SHALL abandon the operation with no result emitted.

Configuration
REQ-027 With EX_MUL_EN defined, MUL SHALL behave as in REQ-019 to REQ-024.
REQ-028 Without EX_MUL_EN, op 9 SHALL behave like an unused code: result 0, 1-cycle latency, ex_busy tied 0, no MUL state or datapath synthesized.

Structure
REQ-029 Package ex_pkg SHALL hold the op-code constants, the ctrl field positions (OP, IMM_SEL, VALID) and MUL_ITERS = 64.
REQ-030 The iterative multiplier SHALL be sub-module ex_mul_seq (start, A, B -> done, product); it is instantiated only under EX_MUL_EN.

Verification
REQ-031 ADD: A=5, B=7, valid -> next cycle MEM_result=12, MEM_rD and MEM_WB_ctrl echo the inputs, ex_busy=0.
REQ-032 IMM path: SUB with A=0, imm=16'hFFFF -> MEM_result=1; SRA with A=64'h8000_0000_0000_0000, B=4 -> 64'hF800_0000_0000_0000.
REQ-033 MUL: A=3, B=-2 -> ex_busy high 65 cycles with bubbles meanwhile, then MEM_result=64'hFFFF_FFFF_FFFF_FFFA.
REQ-034 MUL followed immediately by ADD held in ID -> ADD result appears exactly one cycle after the MUL result.
REQ-035 rst low at MUL iteration 30 -> all outputs 0, ex_busy 0; a subsequent ADD completes in 1 cycle.
REQ-036 Build without EX_MUL_EN: op 9, A=3, B=4 -> MEM_result=0 after 1 cycle, ex_busy never asserted.
